// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: one shift register plus one holding register,
// so a second word can wait while a frame is on the line.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serial_output,
    output logic                 busy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 accept;
    logic                 bit_end;
    logic                 load_direct;

    function automatic logic calc_par(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    assign accept  = tx_valid && !hold_full_q;
    assign bit_end = (cnt_q == 16'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        tx_d        = tx_q;
        load_direct = 1'b0;

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? 16'd0 : 16'(cnt_q + 16'd1);
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    load_direct = 1'b1;
                    shift_d     = tx_data;
                    par_d       = calc_par(tx_data);
                    state_d     = ST_START;
                    tx_d        = 1'b0;
                    cnt_d       = 16'd0;
                    idx_d       = 4'd0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                    idx_d   = 4'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        idx_d = 4'd0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = 4'(idx_q + 4'd1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                    idx_d   = 4'd0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == 4'(STOP_BITS - 1)) begin
                        idx_d = 4'd0;
                        // Buffered word wins; otherwise a word arriving on this edge skips the buffer.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            par_d       = calc_par(hold_q);
                            hold_full_d = 1'b0;
                            state_d     = ST_START;
                            tx_d        = 1'b0;
                        end else if (accept) begin
                            load_direct = 1'b1;
                            shift_d     = tx_data;
                            par_d       = calc_par(tx_data);
                            state_d     = ST_START;
                            tx_d        = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = 4'(idx_q + 4'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (accept && !load_direct) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 4'd0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
        end
    end

    assign tx_ready      = !hold_full_q;
    assign serial_output = tx_q;
    assign busy          = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations share one stimulus bus and are
// checked every cycle against a frame-timeline model of the line.
module tb_uart_tx_cfg;

    localparam int C_T  [4] = '{4, 4, 4, 2};
    localparam int DB_T [4] = '{8, 8, 8, 5};
    localparam int PAR_T[4] = '{0, 2, 1, 0};
    localparam int SB_T [4] = '{1, 1, 1, 2};

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [3:0] rdy, bsy, ser;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[0]), .serial_output(ser[0]), .busy(bsy[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[1]), .serial_output(ser[1]), .busy(bsy[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy[2]), .serial_output(ser[2]), .busy(bsy[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
        .clock(clock), .reset(reset), .tx_data(tx_data[4:0]), .tx_valid(tx_valid),
        .tx_ready(rdy[3]), .serial_output(ser[3]), .busy(bsy[3]));

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int ecount = 0;
    int last_s[4], last_d[4], prev_s[4], prev_d[4], nf[4];
    int acc_edge[3];

    typedef struct {
        int inst;
        int data;
        int nbits;
        int pat;
    } vec_t;
    vec_t vecs[8];

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic int flen(input int i);
        return C_T[i] * (1 + DB_T[i] + ((PAR_T[i] != 0) ? 1 : 0) + SB_T[i]);
    endfunction

    function automatic int frame_bit(input int i, input int d, input int k);
        int ones;
        if (k == 0) return 0;
        if (k <= DB_T[i]) return (d >> (k - 1)) & 1;
        if (PAR_T[i] != 0 && k == DB_T[i] + 1) begin
            ones = 0;
            for (int b = 0; b < DB_T[i]; b++) ones += (d >> b) & 1;
            return (PAR_T[i] == 2) ? (ones % 2) : (1 - ones % 2);
        end
        return 1;
    endfunction

    function automatic int exp_line(input int i, input int e);
        if (nf[i] >= 1 && last_s[i] <= e && e < last_s[i] + flen(i))
            return frame_bit(i, last_d[i], (e - last_s[i]) / C_T[i]);
        if (nf[i] >= 2 && prev_s[i] <= e && e < prev_s[i] + flen(i))
            return frame_bit(i, prev_d[i], (e - prev_s[i]) / C_T[i]);
        return 1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) nf[i] = 0;
    endtask

    // A word lands on the line either right away or where the previous frame ends.
    always @(posedge clock) begin
        ecount = ecount + 1;
        if (!reset && tx_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (nf[i] == 0 || last_s[i] < ecount) begin
                    int s;
                    s = (nf[i] > 0 && last_s[i] + flen(i) > ecount) ? last_s[i] + flen(i) : ecount;
                    prev_s[i] = last_s[i];
                    prev_d[i] = last_d[i];
                    last_s[i] = s;
                    last_d[i] = int'(tx_data) & ((1 << DB_T[i]) - 1);
                    nf[i] = (nf[i] < 2) ? nf[i] + 1 : 2;
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("line%0d@%0d", i, ecount), int'(ser[i]), exp_line(i, ecount));
            check_output($sformatf("busy%0d@%0d", i, ecount), int'(bsy[i]),
                         (nf[i] > 0 && last_s[i] + flen(i) > ecount) ? 1 : 0);
            check_output($sformatf("ready%0d@%0d", i, ecount), int'(rdy[i]),
                         (nf[i] == 0 || last_s[i] <= ecount) ? 1 : 0);
        end
    end

    task automatic wait_all_idle();
        int t;
        t = 0;
        @(negedge clock);
        while (bsy != 4'h0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        check_output("idle_wait", int'(bsy), 0);
    endtask

    task automatic wait_edge(input int target);
        while (ecount < target) @(negedge clock);
    endtask

    // One table word, then sample mid-bit and measure how long busy stays high.
    task automatic apply_stimulus(input int idx);
        vec_t v;
        int   c, n, busy_cnt, len;
        v = vecs[idx];
        c = C_T[v.inst];
        len = v.nbits * c;
        wait_all_idle();
        tx_data  = 8'(v.data);
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        n = ecount;
        busy_cnt = 0;
        for (int k = 0; k < len + 4; k++) begin
            if (bsy[v.inst]) busy_cnt++;
            if ((k % c) == c / 2 && k / c < v.nbits)
                check_output($sformatf("vec%0d_bit%0d", idx, k / c), int'(ser[v.inst]),
                             (v.pat >> (k / c)) & 1);
            @(negedge clock);
        end
        check_output($sformatf("vec%0d_len(start@%0d)", idx, n), busy_cnt, len);
    endtask

    // Holds tx_valid and presents the next word after each acceptance by u0.
    task automatic hold_send(input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2);
        int t;
        tx_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            tx_data = (k == 0) ? w0 : ((k == 1) ? w1 : w2);
            t = 0;
            while (!rdy[0] && t < 200) begin
                @(negedge clock);
                t++;
            end
            check_output($sformatf("hold_send_ready%0d", k), int'(rdy[0]), 1);
            acc_edge[k] = ecount + 1;
            @(negedge clock);
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{inst: 0, data: 'hE6, nbits: 10, pat: 'h3CC};
        vecs[1] = '{inst: 1, data: 'hE6, nbits: 11, pat: 'h7CC};
        vecs[2] = '{inst: 2, data: 'hE6, nbits: 11, pat: 'h5CC};
        vecs[3] = '{inst: 3, data: 'h13, nbits: 8,  pat: 'hE6};
        vecs[4] = '{inst: 0, data: 'h00, nbits: 10, pat: 'h200};
        vecs[5] = '{inst: 0, data: 'hFF, nbits: 10, pat: 'h3FE};
        vecs[6] = '{inst: 1, data: 'h00, nbits: 11, pat: 'h400};
        vecs[7] = '{inst: 2, data: 'h00, nbits: 11, pat: 'h600};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        clear_model();
        #1;
        check_output("reset_line", int'(ser), 15);
        check_output("reset_ready", int'(rdy), 15);
        check_output("reset_busy", int'(bsy), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) apply_stimulus(i);

        // Two words with valid held: second start bit directly follows the stop bit.
        wait_all_idle();
        hold_send(2, 8'h55, 8'hAA, 8'h00);
        check_output("b2b_accept_gap", acc_edge[1] - acc_edge[0], 1);
        wait_edge(acc_edge[0] + 39);
        check_output("b2b_last_stop", int'(ser[0]), 1);
        check_output("b2b_ready_full", int'(rdy[0]), 0);
        @(negedge clock);
        check_output("b2b_next_start", int'(ser[0]), 0);
        check_output("b2b_ready_free", int'(rdy[0]), 1);
        check_output("b2b_busy", int'(bsy[0]), 1);

        // Three words: the third waits for the shifter to reload.
        wait_all_idle();
        hold_send(3, 8'h3C, 8'hA5, 8'h0F);
        check_output("three_word_third_accept", acc_edge[2] - acc_edge[0], 41);

        // Reset during data bit 3 with a word buffered.
        wait_all_idle();
        hold_send(2, 8'h37, 8'hC8, 8'h00);
        wait_edge(acc_edge[0] + 17);
        check_output("pre_reset_bit3", int'(ser[0]), 0);
        check_output("pre_reset_busy", int'(bsy[0]), 1);
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        check_output("async_reset_line", int'(ser), 15);
        check_output("async_reset_ready", int'(rdy), 15);
        check_output("async_reset_busy", int'(bsy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (60) @(negedge clock);
        apply_stimulus(0);

        // Random traffic with occasional resets.
        wait_all_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            tx_valid = ($urandom_range(0, 2) == 0);
            tx_data  = 8'($urandom);
            if ($urandom_range(0, 799) == 0) begin
                #1;
                reset = 1'b1;
                clear_model();
                @(negedge clock);
                reset = 1'b0;
            end
        end
        tx_valid = 1'b0;
        wait_all_idle();
        repeat (4) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame; legal range 5..9.
REQ-003 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Illegal parameter values SHALL cause an elaboration-time error.
REQ-006 clock  input  1: single clock; all state changes on its rising edge.
REQ-007 reset  input  1: asynchronous, active-high reset.
REQ-008 tx_data  input  DATA_BITS: payload word to send.
REQ-009 tx_valid  input  1: tx_data is valid.
REQ-010 tx_ready  output  1: the block can accept a word this cycle.
REQ-011 serial_output  output  1: UART line; idles high.
REQ-012 busy  output  1: a frame is in progress or a word is buffered.

Function
REQ-013 A word SHALL be accepted on any rising edge where tx_valid=1 and tx_ready=1; otherwise tx_data is ignored.
REQ-014 The block SHALL contain one shift register and one holding register; tx_ready SHALL equal NOT(holding register full).
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START on load; START->DATA, DATA->PARITY (or ->STOP if PARITY=0), PARITY->STOP, each after its bit time.
REQ-016 On leaving STOP, the FSM SHALL go to START if a word is available, otherwise to IDLE.
REQ-017 Each bit SHALL hold serial_output for exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads on every bit boundary.
REQ-018 Frame order SHALL be: start (0), data LSB first, optional parity, STOP_BITS ones; frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-019 Even parity bit = XOR of the data bits; odd parity bit = its inverse; parity SHALL be computed from the word as loaded into the shifter.
REQ-020 If IDLE and a word is accepted at edge N, it SHALL go directly to the shifter, and serial_output SHALL be 0 from edge N onward (registered output, no idle gap).
REQ-021 If busy transmitting, an accepted word SHALL go to the holding register.
REQ-022 At the final edge of the last stop bit, if the holding register is full, it SHALL move to the shifter, empty, and start the next start bit with zero idle cycles.
REQ-023 If the holding register is empty and a word is accepted on that same final edge, the word SHALL go directly to the shifter (back-to-back, no gap).
REQ-024 busy SHALL be 1 whenever state != IDLE or the holding register is full.
REQ-025 tx_data changes after acceptance SHALL NOT affect the frame in flight or the buffered word.

Reset
REQ-026 Asserting reset SHALL immediately (asynchronously) force serial_output=1, tx_ready=1, busy=0, state=IDLE, holding register empty, and counters zero.
REQ-027 Reset mid-frame SHALL abort the frame and discard any buffered word.
REQ-028 After reset deasserts, the first accepted word SHALL produce a full, well-formed frame.

Verification
REQ-029 CLKS_PER_BIT=4, 8N1, send 0xE6 -> line 0,0,1,1,0,0,1,1,1,1, each for 4 cycles (40 cycles); busy high for exactly 40 cycles.
REQ-030 8E1 with 0xE6 -> parity bit 1; 8O1 with 0xE6 -> parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.
REQ-031 tx_valid held with 0x55 then 0xAA -> second start bit begins on the cycle after the first stop bit; no idle cycles; the tx_ready pattern matches the holding-register occupancy.
REQ-032 Three words offered back-to-back -> tx_ready=0 while the holding register is full; the third word is accepted only after the shifter reloads; all three frames are correct.
REQ-033 reset pulsed during data bit 3 -> serial_output=1 in the same cycle, buffered word lost; the next word sends correctly.
REQ-034 DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=2, send 0x13 -> line 0,1,1,0,0,1,1,1, each bit 2 cycles (16 cycles).
